multi_edge_detector: RTL and testbench

//   WIDTH-channel edge detector for asynchronous or slow external inputs (buttons, status pins).
//   Per channel: synchronise the input, detect rising/falling edges, emit registered
//   one-cycle pulses, and keep a sticky event flag per channel with write-1-to-clear.
//   An OR-reduced irq output goes to the interrupt/status logic.

---
 rtl/multi_edge_detector.sv | 117 +++++++++++
 tb/tb_multi_edge_detector.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// WIDTH-channel edge detector: input synchroniser, registered rise/fall pulses and sticky
// write-1-to-clear event flags. Define EDGE_DET_DEBOUNCE_EN to add a per-channel debounce filter.
module multi_edge_detector #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sig_in,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic [WIDTH-1:0] clr,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] event_flag,
   output logic             irq
);

   if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 1 || SYNC_STAGES > 4 ||
       DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_params
      $error("multi_edge_detector: parameter out of range");
   end

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] flag_q, flag_d;

   always_comb begin
      sync_d[0] = sig_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

`ifdef EDGE_DET_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] filt_q, filt_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // A change is accepted only after DEBOUNCE_CYCLES consecutive samples disagree with the filter
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync_q[SYNC_STAGES-1][i] != filt_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               filt_d[i] = sync_q[SYNC_STAGES-1][i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         filt_q <= filt_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign stable = filt_q;
`else
   assign stable = sync_q[SYNC_STAGES-1];
`endif

   // Set has priority over clr so an edge arriving during a clear is never lost
   always_comb begin
      prev_d = stable;
      rise_d = stable & ~prev_q;
      fall_d = ~stable & prev_q;
      flag_d = (rise_q & rise_en) | (fall_q & fall_en) | (flag_q & ~clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         prev_q <= '0;
         rise_q <= '0;
         fall_q <= '0;
         flag_q <= '0;
      end else begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_d[k];
         end
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         flag_q <= flag_d;
      end
   end

   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign level_out  = stable;
   assign event_flag = flag_q;
   assign irq        = |flag_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: a cycle-history model checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_multi_edge_detector;

   localparam int WIDTH = 8;
   localparam int SYNC  = 2;
   localparam int DEB   = 4;
`ifdef EDGE_DET_DEBOUNCE_EN
   localparam int LAT      = SYNC + 1 + DEB;
   localparam int T4_EXPECT = 0;
`else
   localparam int LAT      = SYNC + 1;
   localparam int T4_EXPECT = 3;
`endif

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] sig_in;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
   logic [WIDTH-1:0] level_out;
   logic [WIDTH-1:0] event_flag;
   logic             irq;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   multi_edge_detector #(
      .WIDTH(WIDTH),
      .SYNC_STAGES(SYNC),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sig_in(sig_in),
      .rise_en(rise_en),
      .fall_en(fall_en),
      .clr(clr),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .level_out(level_out),
      .event_flag(event_flag),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic apply_stimulus(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] re,
                                 input logic [WIDTH-1:0] fe, input logic [WIDTH-1:0] c);
      sig_in  = s;
      rise_en = re;
      fall_en = fe;
      clr     = c;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: every input sample since reset is kept; outputs are derived from that history
   logic [WIDTH-1:0] hist [0:4095];
   int               n_edges;
   logic [WIDTH-1:0] m_filt, m_last_st, m_rise, m_fall, m_flag, m_level;

   function automatic logic [WIDTH-1:0] sample_at(input int idx);
      if (idx < 1 || idx > 4095) return '0;
      return hist[idx];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n_edges   = 0;
         m_filt    = '0;
         m_last_st = '0;
         m_rise    = '0;
         m_fall    = '0;
         m_flag    = '0;
         m_level   = '0;
      end else begin : model_step
         logic [WIDTH-1:0] st_pre;
         logic [WIDTH-1:0] old_s;
         logic             all_diff;
         n_edges = n_edges + 1;
         if (n_edges <= 4095) hist[n_edges] = sig_in;
`ifdef EDGE_DET_DEBOUNCE_EN
         st_pre = m_filt;
`else
         st_pre = sample_at(n_edges - SYNC);
`endif
         m_flag    = (m_rise & rise_en) | (m_fall & fall_en) | (m_flag & ~clr);
         m_rise    = st_pre & ~m_last_st;
         m_fall    = ~st_pre & m_last_st;
         m_last_st = st_pre;
`ifdef EDGE_DET_DEBOUNCE_EN
         for (int b = 0; b < WIDTH; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++) begin
               old_s = sample_at(n_edges - SYNC - k);
               if (old_s[b] == m_filt[b]) all_diff = 1'b0;
            end
            if (all_diff) m_filt[b] = ~m_filt[b];
         end
         m_level = m_filt;
`else
         old_s    = '0;
         all_diff = 1'b0;
         m_level  = sample_at(n_edges - SYNC + 1);
`endif
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check_output("cyc_rise_pulse", rise_pulse, m_rise);
         check_output("cyc_fall_pulse", fall_pulse, m_fall);
         check_output("cyc_level_out", level_out, m_level);
         check_output("cyc_event_flag", event_flag, m_flag);
         check_output("cyc_irq", irq, |m_flag);
      end
   end

   initial begin
      int  n_rise;
      int  n_fall;
      int  n_both;
      int  n_long;
      logic last_r;
      logic last_f;

      rst = 1'b1;
      apply_stimulus(8'h00, 8'h00, 8'h00, 8'h00);
      wait_cycles(2);
      cmp_en = 1'b1;
      check_output("reset_rise", rise_pulse, 8'h00);
      check_output("reset_fall", fall_pulse, 8'h00);
      check_output("reset_level", level_out, 8'h00);
      check_output("reset_flag", event_flag, 8'h00);
      check_output("reset_irq", irq, 1'b0);
      rst = 1'b0;
      wait_cycles(3);

      // Test 1: rising edge on channel 0 with all rise enables on
      apply_stimulus(8'h01, 8'hFF, 8'h00, 8'h00);
      wait_cycles(LAT - 1);
      check_output("t1_rise_early", rise_pulse, 8'h00);
      wait_cycles(1);
      check_output("t1_rise", rise_pulse, 8'h01);
      check_output("t1_flag_not_yet", event_flag, 8'h00);
      wait_cycles(1);
      check_output("t1_rise_gone", rise_pulse, 8'h00);
      check_output("t1_flag", event_flag, 8'h01);
      check_output("t1_irq", irq, 1'b1);

      // Test 2: falling edge on channel 3 with fall enables off
      apply_stimulus(8'h09, 8'h00, 8'h00, 8'h00);
      wait_cycles(LAT + 2);
      check_output("t2_no_rise_flag", event_flag, 8'h01);
      sig_in = 8'h01;
      wait_cycles(LAT);
      check_output("t2_fall", fall_pulse, 8'h08);
      wait_cycles(1);
      check_output("t2_fall_gone", fall_pulse, 8'h00);
      check_output("t2_flag_kept", event_flag, 8'h01);

      // Test 3: clear, then clear coinciding with a new rising edge
      clr = 8'h01;
      wait_cycles(1);
      clr = 8'h00;
      check_output("t3_cleared", event_flag, 8'h00);
      check_output("t3_irq_low", irq, 1'b0);
      sig_in = 8'h00;
      wait_cycles(LAT + 2);
      rise_en = 8'h01;
      sig_in  = 8'h01;
      wait_cycles(LAT);
      check_output("t3_rise", rise_pulse, 8'h01);
      clr = 8'h01;
      wait_cycles(1);
      check_output("t3_set_wins", event_flag, 8'h01);
      clr = 8'h00;
      wait_cycles(1);
      check_output("t3_flag_held", event_flag, 8'h01);
      clr = 8'hFF;
      wait_cycles(1);
      clr = 8'h00;

      // Test 4: channel 2 toggles every 2 cycles, then a one-cycle blip on channel 1
      apply_stimulus(8'h00, 8'h00, 8'h00, 8'h00);
      wait_cycles(LAT + 2);
      n_rise = 0;
      n_fall = 0;
      n_both = 0;
      n_long = 0;
      last_r = 1'b0;
      last_f = 1'b0;
      for (int i = 0; i < 24 + LAT; i++) begin
         @(negedge clk);
         if (rise_pulse[2]) n_rise++;
         if (fall_pulse[2]) n_fall++;
         if (rise_pulse[2] && fall_pulse[2]) n_both++;
         if ((rise_pulse[2] && last_r) || (fall_pulse[2] && last_f)) n_long++;
         last_r = rise_pulse[2];
         last_f = fall_pulse[2];
         if (i < 12 && i % 2 == 0) sig_in[2] = ~sig_in[2];
      end
      check_output("t4_rise_count", n_rise, T4_EXPECT);
      check_output("t4_fall_count", n_fall, T4_EXPECT);
      check_output("t4_overlap", n_both, 0);
      check_output("t4_long_pulse", n_long, 0);
      sig_in = 8'h02;
      wait_cycles(1);
      sig_in = 8'h00;
      wait_cycles(LAT + 3);

      // Test 5: input high through reset release, then asynchronous reset mid-pulse
      apply_stimulus(8'hFF, 8'hFF, 8'h00, 8'h00);
      rst = 1'b1;
      wait_cycles(2);
      check_output("t5_level_in_reset", level_out, 8'h00);
      rst = 1'b0;
      wait_cycles(LAT - 1);
      check_output("t5_rise_early", rise_pulse, 8'h00);
      wait_cycles(1);
      check_output("t5_rise", rise_pulse, 8'hFF);
      wait_cycles(1);
      check_output("t5_flag", event_flag, 8'hFF);
      check_output("t5_irq", irq, 1'b1);
      sig_in = 8'h00;
      wait_cycles(LAT);
      check_output("t5_fall", fall_pulse, 8'hFF);
      #2 rst = 1'b1;
      #1;
      check_output("t5_async_fall", fall_pulse, 8'h00);
      check_output("t5_async_flag", event_flag, 8'h00);
      check_output("t5_async_irq", irq, 1'b0);
      wait_cycles(2);
      rst = 1'b0;
      wait_cycles(2);

`ifdef EDGE_DET_DEBOUNCE_EN
      // Test 6: short glitch rejected, long pulse accepted after the filter delay
      apply_stimulus(8'h01, 8'h00, 8'h00, 8'h00);
      wait_cycles(3);
      sig_in = 8'h00;
      n_rise = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (rise_pulse[0]) n_rise++;
      end
      check_output("t6_glitch", n_rise, 0);
      sig_in = 8'h01;
      wait_cycles(6);
      sig_in = 8'h00;
      wait_cycles(1);
      check_output("t6_rise", rise_pulse, 8'h01);
      wait_cycles(1);
      check_output("t6_rise_gone", rise_pulse, 8'h00);
      wait_cycles(15);
`endif

      // Directed vector sweep with varied hold times, checked by the per-cycle model
      for (int i = 0; i < 64; i++) begin
         apply_stimulus(8'(i * 29) ^ 8'(i >> 2), 8'(i * 13), 8'(~(i * 7)),
                        (i % 5 == 0) ? 8'hA5 : 8'h00);
         wait_cycles(1 + i % 6);
      end
      apply_stimulus(8'h00, 8'h00, 8'h00, 8'h00);
      wait_cycles(LAT + 4);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
